// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - one-deep pipeline register stage with optional skid buffer
//
// Purpose:
//   Registered valid/ready pipeline stage with one cycle of latency.
//   out_valid and out_data always come straight from flops.
//   A saturating counter records the cycles in which the output is stalled.
//
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   - A skid register and a FULL state are present, and in_ready is
//               registered. Upstream then never sees a same-cycle path from
//               out_ready.
//   undefined - There is no skid register. in_ready = out_ready || !out_valid,
//               and it is combinational.
//
// Parameters:
//   WIDTH     - payload width in bits
//   RESET_VAL - payload value loaded on reset and flush (NOP bubble)
//   CNT_W     - width of the stall-cycle counter
//
// Ports:
//   clk       in   clock, rising-edge active
//   reset     in   asynchronous active-high reset
//   flush     in   synchronous squash of every held entry
//   in_valid  in   upstream entry present
//   in_data   in   upstream payload [WIDTH]
//   in_ready  out  stage accepts an entry this cycle
//   out_valid out  downstream entry present
//   out_data  out  downstream payload [WIDTH]
//   out_ready in   downstream accepts an entry this cycle
//   cnt_clr   in   synchronous clear of stall_cnt
//   stall_cnt out  saturating count of stalled cycles [CNT_W]

module pipe_stage_skid #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_BUSY  = 1'b1
    } state_t;
`endif

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_emit;
    logic             w_stalled;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;

    // Ready is a flop image of "not FULL". Upstream timing is therefore
    // isolated from out_ready.
    assign w_in_ready = r_in_ready;
`else
    // Without a skid slot, an entry can be taken only if the output is free
    // or is leaving on this edge.
    assign w_in_ready = out_ready || !r_out_valid;
`endif

    assign w_accept  = in_valid && w_in_ready;
    assign w_emit    = r_out_valid && out_ready;
    assign w_stalled = r_out_valid && !out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign stall_cnt = r_stall_cnt;

    // Stage FSM. Flush takes priority over every handshake. An entry accepted
    // on the flush edge is simply never captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= RESET_VAL;
`ifdef PIPE_STAGE_SKID_EN
            r_skid      <= RESET_VAL;
            r_in_ready  <= 1'b1;
`endif
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_out_data  <= RESET_VAL;
`ifdef PIPE_STAGE_SKID_EN
            r_skid      <= RESET_VAL;
            r_in_ready  <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_accept && w_emit) begin
                        r_out_data <= in_data;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (w_accept) begin
                        // Output is stalled, so park the new entry behind it.
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= S_FULL;
`endif
                    end else if (w_emit) begin
                        // out_data keeps its last value; out_valid qualifies it.
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                S_FULL: begin
                    if (w_emit) begin
                        r_out_data <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
`endif
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The stall counter saturates instead of wrapping. Flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int          WIDTH = 32;
    localparam int          CNT_W = 4;
    localparam logic [31:0] RV    = 32'hA5A5_0001;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] sb[$];

    pipe_stage_skid #(.WIDTH(WIDTH), .RESET_VAL(RV), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: bookkeeping at the falling edge, then returns 1ns after the rising edge.
    task automatic cycle();
        logic [WIDTH-1:0] exp_d;
        @(negedge clk);
`ifndef PIPE_STAGE_SKID_EN
        check("in_ready_comb", {63'd0, in_ready}, {63'd0, out_ready || !out_valid});
`endif
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty_on_emit", {63'd0, sb.size() > 0}, 64'd1);
                if (sb.size() > 0) begin
                    exp_d = sb.pop_front();
                    check("emit_order", out_data, exp_d);
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, RV);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single entry, one-cycle latency, then back to EMPTY.
        in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b1;
        cycle();
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 32'h1234_5678);
        in_valid = 1'b0;
        cycle();
        check("single_empty", out_valid, 0);
        check("empty_retains", out_data, 32'h1234_5678);

        // Stall counting, saturation and clear.
        in_valid = 1'b1; in_data = 32'h0000_00A1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("stall_hold_data", out_data, 32'h0000_00A1);
            check("stall_cnt_sat", stall_cnt, (k < 15) ? k : 15);
        end
        cnt_clr = 1'b1;
        cycle();
        check("cnt_clr_wins", stall_cnt, 0);
        cnt_clr = 1'b0;
        cycle();
        check("cnt_after_clr", stall_cnt, 1);

        // Flush while stalled: entry dropped, counter keeps counting through it.
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0BAD;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_data", out_data, RV);
        check("flush_in_ready", in_ready, 1);
        check("flush_keeps_cnt", stall_cnt, 2);

        // Flush while EMPTY with a concurrent accept: the accepted entry is discarded.
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0BAE; out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_accept_discard", out_valid, 0);
        cycle();
        check("flush_accept_stays", out_valid, 0);

        // Back-to-back stream at full throughput.
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = i;
            cycle();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, i);
        end
        in_valid = 1'b0;
        cycle();
        check("stream_drained", out_valid, 0);

`ifdef PIPE_STAGE_SKID_EN
        // Skid fill: two accepts, then ready drops, and the skid drains in order.
        in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0; in_data = 32'h2;
        cycle();
        check("skid_full_ready", in_ready, 0);
        check("skid_hold_data", out_data, 32'h1);
        in_data = 32'h3;
        cycle();
        check("skid_still_full", in_ready, 0);
        check("skid_hold_data2", out_data, 32'h1);
        out_ready = 1'b1;
        cycle();
        check("skid_drain_data", out_data, 32'h2);
        check("skid_drain_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("skid_done", out_valid, 0);

        // Flush from FULL with a concurrent entry.
        in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
        cycle();
        in_data = 32'h12;
        cycle();
        check("full_before_flush", in_ready, 0);
        flush = 1'b1; in_data = 32'h13;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("full_flush_valid", out_valid, 0);
        check("full_flush_data", out_data, RV);
        check("full_flush_ready", in_ready, 1);
        cycle();
        cycle();
        check("full_flush_nothing", out_valid, 0);
`endif

        // Asynchronous reset between edges while BUSY.
        in_valid = 1'b1; in_data = 32'h0000_0055; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        check("pre_areset_busy", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", out_valid, 0);
        check("areset_data", out_data, RV);
        check("areset_cnt", stall_cnt, 0);
        check("areset_in_ready", in_ready, 1);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0077; out_ready = 1'b1;
        cycle();
        check("post_reset_accept", out_data, 32'h0000_0077);
        check("post_reset_valid", out_valid, 1);

        // Random valid/ready traffic against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && (out_valid || sb.size() > 0); c++) cycle();
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter WIDTH, 32, payload width in bits (>=1).
REQ-002 Parameter RESET_VAL, {WIDTH{1'b0}}, payload value loaded on reset and flush (NOP bubble).
REQ-003 Parameter CNT_W, 16, width of the stall-cycle counter (>=1).
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port flush  input  1  synchronous squash of all held entries.
REQ-007 Port in_valid  input  1  upstream entry present.
REQ-008 Port in_data  input  WIDTH  upstream payload.
REQ-009 Port in_ready  output  1  stage accepts an entry this cycle.
REQ-010 Port out_valid  output  1  downstream entry present.
REQ-011 Port out_data  output  WIDTH  downstream payload.
REQ-012 Port out_ready  input  1  downstream accepts an entry this cycle (deasserted = stall).
REQ-013 Port cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-014 Port stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-015 Accept = in_valid && in_ready; emit = out_valid && out_ready; no other event moves data.
REQ-016 Latency in-to-out 1 cycle: an entry accepted at edge N appears on out_data/out_valid after edge N.
REQ-017 out_data, out_valid come directly from flops; no combinational path from in_* to out_*.
REQ-018 Entries leave in acceptance order; none duplicated or dropped except by flush.
REQ-019 States: EMPTY (out_valid=0), BUSY (out_valid=1, skid empty), FULL (out_valid=1, skid holds one entry).
REQ-020 EMPTY: accept -> BUSY; else stay.
REQ-021 BUSY: accept and emit -> BUSY with new entry; accept, no emit -> FULL (entry into skid); emit, no accept -> EMPTY; neither -> stay.
REQ-022 FULL: emit -> BUSY, skid entry moves to output; no emit -> stay; no accept possible.
REQ-023 in_ready is registered: 1 in EMPTY/BUSY, 0 in FULL; does not depend on out_ready in same cycle.
REQ-024 flush asserted at an edge: next state EMPTY, out_data=RESET_VAL, skid cleared, any entry accepted that cycle discarded; flush overrides all other events.
REQ-025 out_data held stable while out_valid=1 and out_ready=0.
REQ-026 In EMPTY out_data retains last value (RESET_VAL after reset/flush); consumers qualify with out_valid.
REQ-027 stall_cnt increments by 1 each edge with out_valid=1 and out_ready=0; saturates at 2^CNT_W-1, no wrap.
REQ-028 cnt_clr sets stall_cnt to 0, overriding same-cycle increment; flush does not affect stall_cnt.

Reset
REQ-029 reset asserted clears asynchronously, no clock required: state EMPTY, out_valid=0, out_data=RESET_VAL, skid empty, stall_cnt=0, in_ready=1.
REQ-030 Reset mid-transfer discards all held entries; first accept possible at first rising edge after reset deasserts.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: skid register and FULL state present, REQ-019..REQ-023 apply as written.
REQ-032 Macro PIPE_STAGE_SKID_EN undefined: no skid register, no FULL state; in_ready = out_ready || !out_valid (combinational); BUSY with accept and no emit impossible; all other requirements unchanged.

Verification
REQ-033 WIDTH=32: reset, in_data=0x12345678 valid 1 cycle, out_ready=1 -> out_valid=1, out_data=0x12345678 exactly one cycle later, then EMPTY.
REQ-034 Stream 0x1,0x2,0x3 with out_ready=0 from 2nd cycle (skid on) -> in_ready falls after 2 accepts, out_data holds 0x1; out_ready=1 -> 0x1,0x2,0x3 emitted in order, none lost.
REQ-035 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, out_data=RESET_VAL, in_ready=1, flushed and concurrent entries never emitted.
REQ-036 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; cnt_clr=1 with stall -> stall_cnt=0 next cycle.
REQ-037 Assert reset asynchronously between edges while BUSY -> out_valid=0, out_data=RESET_VAL immediately, before next edge.
REQ-038 Skid off, random valid/ready 10k cycles -> in_ready == out_ready || !out_valid every cycle, scoreboard matches order.
